// File: rtl/ohm_div.sv
// Resistance calculator: R = floor(V * SCALE / I) from ADC-encoded voltage and current codes.
// A product stage followed by an 11-step restoring divider gives a fixed 14-cycle latency.
module ohm_div #(
  parameter logic [10:0] SCALE = 11'd1315
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [11:0] v_in,
  input  logic [11:0] i_in,
  output logic        valid_out,
  output logic [11:0] r_out,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Handshake: valid_in is a one-cycle strobe taken only in IDLE with no capture
  // pending; valid_out is a one-cycle strobe, r_out holds until the next result.

  logic [1:0]  state_q, state_d;
  logic        cap_q, cap_d;
  logic [10:0] v_q, v_d;
  logic [10:0] i_q, i_d;
  logic [10:0] rem_q, rem_d;
  logic [10:0] lo_q, lo_d;
  logic [10:0] quo_q, quo_d;
  logic        sat_q, sat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_out_q, valid_out_d;
  logic [11:0] r_out_q, r_out_d;

  logic [11:0] v_dec, i_dec;
  logic [21:0] prod;
  logic [21:0] div_lim;
  logic [11:0] trial;
  logic [11:0] diff;
  logic        fits;
  logic [10:0] r_final;

  always_comb begin
    v_dec   = v_in ^ 12'h7FF;
    i_dec   = i_in ^ 12'h7FF;
    prod    = 22'(v_q) * 22'(SCALE);
    div_lim = {i_q, 11'd0};
    trial   = {rem_q, lo_q[10]};
    diff    = trial - {1'b0, i_q};
    fits    = (trial >= {1'b0, i_q});
    r_final = sat_q ? 11'h7FF : quo_q;
  end

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    v_d         = v_q;
    i_d         = i_q;
    rem_d       = rem_q;
    lo_d        = lo_q;
    quo_d       = quo_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    valid_out_d = 1'b0;
    r_out_d     = r_out_q;

    case (state_q)
      IDLE: begin
        if (cap_q) begin
          cap_d   = 1'b0;
          state_d = MUL;
        end else if (valid_in) begin
          // Negative decoded codes clamp to zero before use.
          cap_d = 1'b1;
          v_d   = v_dec[11] ? 11'd0 : v_dec[10:0];
          i_d   = i_dec[11] ? 11'd0 : i_dec[10:0];
        end
      end
      MUL: begin
        // A quotient of 2048 or more cannot fit in 11 bits; I = 0 lands here too.
        sat_d   = (i_q == 11'd0) || (prod >= div_lim);
        rem_d   = prod[21:11];
        lo_d    = prod[10:0];
        quo_d   = 11'd0;
        cnt_d   = 4'd0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = fits ? diff[10:0] : trial[10:0];
        lo_d  = {lo_q[9:0], 1'b0};
        quo_d = {quo_q[9:0], fits};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_out_d = 1'b1;
        r_out_d     = {1'b0, r_final} ^ 12'h7FF;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_q       <= 1'b0;
      v_q         <= 11'd0;
      i_q         <= 11'd0;
      rem_q       <= 11'd0;
      lo_q        <= 11'd0;
      quo_q       <= 11'd0;
      sat_q       <= 1'b0;
      cnt_q       <= 4'd0;
      valid_out_q <= 1'b0;
      r_out_q     <= 12'h7FF;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      v_q         <= v_d;
      i_q         <= i_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      quo_q       <= quo_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      r_out_q     <= r_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign r_out     = r_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ohm_div.sv
// Directed bench for ohm_div: hand-computed resistance vectors, latency, ignored
// mid-operation strobes and reset abort.
module tb_ohm_div;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [11:0] v_in;
  logic [11:0] i_in;
  logic        valid_out;
  logic [11:0] r_out;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];

  ohm_div dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .v_in      (v_in),
    .i_in      (i_in),
    .valid_out (valid_out),
    .r_out     (r_out),
    .state_dbg (state_dbg)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] enc(input int x);
    logic [11:0] t;
    t = x[11:0];
    return t ^ 12'h7FF;
  endfunction

  // ---- drivers ----
  // Called #1 after a rising edge; the next edge samples valid_in.
  task automatic start(input logic [11:0] vc, input logic [11:0] ic);
    v_in     = vc;
    i_in     = ic;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    v_in     = 12'($urandom_range(0, 4095));
    i_in     = 12'($urandom_range(0, 4095));
  endtask

  // Watches 20 cycles after the sampling edge; optionally fires a stray strobe at cycle stray_k.
  task automatic collect(input string tag, input int stray_k,
                         input logic [11:0] sv, input logic [11:0] si);
    int          pulses;
    int          lat;
    logic [11:0] got;
    logic [11:0] exp;
    pulses = 0;
    lat    = -1;
    got    = 12'hFFF;
    for (int k = 1; k <= 20; k++) begin
      if (k == stray_k) begin
        v_in     = sv;
        i_in     = si;
        valid_in = 1'b1;
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = r_out;
        end
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
    check({tag, "_lat"}, 32'(lat), 32'd14);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_r"}, 32'(got), 32'(exp));
    check({tag, "_hold"}, 32'(r_out), 32'(exp));
  endtask

  task automatic run_op(input string tag, input int v, input int i, input logic [11:0] exp_r);
    exp_q.push_back(exp_r);
    start(enc(v), enc(i));
    collect(tag, 0, 12'h000, 12'h000);
  endtask

  // ---- directed vectors: decoded V, decoded I, expected r_out ----
  localparam int NV = 14;
  int tv_v[NV] = '{25, 449, 698, 500, 0, -5, 100, 2047, 2046, 2047, 1, 2, 100, 3};
  int tv_i[NV] = '{418, 627, 418, 0, 100, 100, -1, 2047, 1315, 1315, 1, 1, 200, 7};
  logic [11:0] tv_r[NV] = '{12'h7B1, 12'h452, 12'h000, 12'h000, 12'h7FF, 12'h7FF, 12'h000,
                            12'h2DC, 12'h001, 12'h000, 12'h2DC, 12'h000, 12'h56E, 12'h5CC};

  initial begin
    int pulses;
    reset    = 1'b1;
    valid_in = 1'b0;
    v_in     = 12'h000;
    i_in     = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_out", 32'(r_out), 32'h7FF);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // First request right after reset release.
    for (int n = 0; n < NV; n++) begin
      run_op($sformatf("vec%0d", n), tv_v[n], tv_i[n], tv_r[n]);
    end

    // A second strobe while busy is ignored; only the first result appears.
    exp_q.push_back(12'h7B1);
    start(enc(25), enc(418));
    collect("busy_strobe", 3, enc(449), enc(627));

    // Reset five cycles into an operation aborts it.
    start(enc(449), enc(627));
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_r_out", 32'(r_out), 32'h7FF);
    check("abort_valid", 32'(valid_out), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_r_idle", 32'(r_out), 32'h7FF);

    run_op("after_abort", 449, 627, 12'h452);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
